song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Score player that sits directly upstream of the note decoder.
- Steps through a song memory of timed note events and drives the 27-bit three-voice notes bus. Each voice field is 7-bit note, 0 = silent, plus 2-bit waveform select.
- Holds each event for a programmable number of tempo ticks, then fetches the next event.
- Supports play, stop, loop and end-of-song detection.

Parameters:
- ADDR_W, 8, song memory address width (song length up to 2^ADDR_W events).
- DUR_W, 8, event duration field width, in tempo ticks.
- TICK_DIV, 50000, clk cycles per tempo tick (legal minimum 1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- play  input  1  level/pulse; starts playback from address 0 when in IDLE or DONE.
- stop  input  1  aborts playback; has priority over play.
- loop_en  input  1  on end marker, restart at address 0 instead of finishing.
- mem_addr  output  ADDR_W  song memory read address.
- mem_rd_en  output  1  song memory read strobe.
- mem_data  input  27+DUR_W  event word. [26:0] is the notes word, same layout as the decoder input. [26+DUR_W:27] is the duration. Memory is synchronous with 1-cycle read latency.
- notes  output  27  registered notes bus to the note decoder.
- playing  output  1  high in FETCH, WAIT and HOLD.
- song_done  output  1  one-cycle pulse on entering DONE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; addr, notes, mem_rd_en, playing, song_done, tick and duration counters all 0.
  - Reset asserted mid-playback behaves identically; it takes effect at the next edge.
- Priority: reset > stop > play.
  - stop in any state: next cycle state=IDLE, notes=0, mem_rd_en=0, playing=0, no song_done pulse.
- IDLE / DONE:
  - notes=0.
  - play=1 and stop=0: addr<=0 and go to FETCH.
- FETCH (1 cycle): mem_rd_en=1, mem_addr=addr; go to WAIT. notes keep their previous value.
- WAIT (1 cycle): mem_data is valid. Let dur = duration field.
  - dur==0 (end marker), loop_en=1: addr<=0, go to FETCH. No song_done pulse; notes unchanged.
  - dur==0, loop_en=0: notes<=0, song_done pulse, go to DONE.
  - dur!=0: notes<=mem_data[26:0], dur_cnt<=dur, prescaler<=0, go to HOLD.
- HOLD:
  - Prescaler counts 0..TICK_DIV-1; a tick is generated at TICK_DIV-1 and the prescaler wraps to 0.
  - On a tick, dur_cnt decrements.
  - On a tick with dur_cnt==1: addr<=addr+1 (modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0 regardless of loop_en), then go to FETCH.
- Timing:
  - play seen at edge N puts FETCH at cycle N+1 and first notes visible at N+3.
  - Steady-state period per event = dur*TICK_DIV + 2 cycles (FETCH+WAIT overhead).
  - notes never glitch to 0 between consecutive events.
- play asserted while playing: ignored; no restart, timing unaffected.
- Rests: a note field of 0 is passed through unchanged (the decoder disables that voice).
- Widths: dur_cnt is DUR_W bits; the prescaler is ceil(log2(TICK_DIV)) bits, minimum 1.
- mem_rd_en is high only in FETCH; mem_addr holds addr in all states.

Test Plan:
- Reset → with TICK_DIV=4, ADDR_W=8, DUR_W=8, assert reset 3 cycles → notes=0, playing=0, mem_rd_en=0, song_done=0, mem_addr=0.
- Basic play → setup:
  - ROM [0]={notes 27'h0000041, dur 3}, [1]={27'h0208283, dur 2}, [2]={dur 0}; loop_en=0; play pulse at cycle 0.
  - Response: mem_rd_en=1 with addr 0 at cycle 1; notes=27'h41 at cycle 3; notes=27'h0208283 at cycle 17; song_done pulses at cycle 27; notes=0 from cycle 27; playing=0.
- Loop → same ROM with loop_en=1 → no song_done; notes return to 27'h41 at cycle 29 and the sequence repeats.
- Stop mid-HOLD → stop at cycle 8 → notes=0 and playing=0 at cycle 9. Then stop and play asserted together → remains IDLE.
- Address wrap → ADDR_W=2, four entries all dur=1 → fetch order 0,1,2,3,0 with no song_done.
- Redundant play → play re-pulsed at cycle 10 of the basic scenario → identical timing; notes change at cycle 17 as before.

Source files
------------

// File: rtl/song_sequencer_if.sv
// Song memory read port shared between the sequencer (master) and the event ROM (slave).
// The event word carries the 27-bit notes field in [26:0] and the duration above it.
interface song_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DUR_W  = 8
);
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd_en;
    logic [26+DUR_W:0]   mem_data;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_data
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_data
    );
endinterface

// File: rtl/song_sequencer.sv
// Score player: steps through timed note events in a synchronous song memory and
// drives the registered three-voice notes bus feeding the note decoder.
module song_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    song_sequencer_if.master  mem,
    output logic [26:0]       notes,
    output logic              playing,
    output logic              song_done
);
    localparam int PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int VOICES  = 3;
    localparam int VOICE_W = 9;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DUR_W-1:0]    dur_cnt_reg, dur_cnt_next;
    logic [PS_W-1:0]     prescaler_reg, prescaler_next;
    logic [26:0]         notes_next;
    logic [VOICE_W-1:0]  voice_reg [VOICES];
    logic                song_done_reg, song_done_next;
    logic [DUR_W-1:0]    dur;
    logic                tick;
    logic                last_tick;

    assign dur       = mem.mem_data[26+DUR_W:27];
    assign tick      = (state_reg == S_HOLD) && (prescaler_reg == PS_LAST);
    assign last_tick = tick && (dur_cnt_reg == DUR_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: if (play) state_next = S_FETCH;
                S_FETCH:        state_next = S_WAIT;
                S_WAIT: begin
                    if (dur == '0) begin
                        state_next = loop_en ? S_FETCH : S_DONE;
                    end else begin
                        state_next = S_HOLD;
                    end
                end
                S_HOLD:         if (last_tick) state_next = S_FETCH;
                default:        state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem.mem_rd_en = 1'b0;
        playing       = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem.mem_rd_en = 1'b1;
                playing       = 1'b1;
            end
            S_WAIT, S_HOLD: playing = 1'b1;
            default: ;
        endcase
    end

    // Datapath: notes only change on entering HOLD, IDLE or DONE, so consecutive
    // events hand over without a silent gap.
    always_comb begin
        addr_next      = addr_reg;
        dur_cnt_next   = dur_cnt_reg;
        prescaler_next = prescaler_reg;
        notes_next     = notes;
        song_done_next = 1'b0;
        if (stop) begin
            notes_next     = '0;
            prescaler_next = '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    notes_next = '0;
                    if (play) addr_next = '0;
                end
                S_WAIT: begin
                    if (dur == '0) begin
                        if (loop_en) begin
                            addr_next = '0;
                        end else begin
                            notes_next     = '0;
                            song_done_next = 1'b1;
                        end
                    end else begin
                        notes_next     = mem.mem_data[26:0];
                        dur_cnt_next   = dur;
                        prescaler_next = '0;
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        prescaler_next = '0;
                        dur_cnt_next   = dur_cnt_reg - DUR_W'(1);
                        if (last_tick) addr_next = addr_reg + ADDR_W'(1);
                    end else begin
                        prescaler_next = prescaler_reg + PS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= '0;
            dur_cnt_reg   <= '0;
            prescaler_reg <= '0;
            song_done_reg <= 1'b0;
        end else begin
            addr_reg      <= addr_next;
            dur_cnt_reg   <= dur_cnt_next;
            prescaler_reg <= prescaler_next;
            song_done_reg <= song_done_next;
        end
    end

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
        always_ff @(posedge clk) begin
            if (reset) begin
                voice_reg[gi] <= '0;
            end else begin
                voice_reg[gi] <= notes_next[gi*VOICE_W +: VOICE_W];
            end
        end
    end

    assign notes        = {voice_reg[2], voice_reg[1], voice_reg[0]};
    assign song_done    = song_done_reg;
    assign mem.mem_addr = addr_reg;
endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed events (read, notes change, done, playing)
// with their cycle numbers; per-DUT monitors pop and compare whenever an event appears.
`timescale 1ns/1ps
module tb_song_sequencer;
    localparam int DUR_W = 8;
    localparam int TD    = 4;

    typedef struct {
        int          kind;
        logic [31:0] value;
        int          cyc;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, play, stop, loop_en;
    logic [26:0] notes;
    logic        playing, song_done;
    logic        play_b, stop_b, loop_en_b;
    logic [26:0] notes_b;
    logic        playing_b, song_done_b;

    song_sequencer_if #(.ADDR_W(8), .DUR_W(DUR_W)) mem_a ();
    song_sequencer_if #(.ADDR_W(2), .DUR_W(DUR_W)) mem_b ();

    song_sequencer #(.ADDR_W(8), .DUR_W(DUR_W), .TICK_DIV(TD)) dut_a (
        .clk(clk), .reset(reset), .play(play), .stop(stop), .loop_en(loop_en),
        .mem(mem_a), .notes(notes), .playing(playing), .song_done(song_done)
    );

    song_sequencer #(.ADDR_W(2), .DUR_W(DUR_W), .TICK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .play(play_b), .stop(stop_b), .loop_en(loop_en_b),
        .mem(mem_b), .notes(notes_b), .playing(playing_b), .song_done(song_done_b)
    );

    logic [26+DUR_W:0] rom_a [256];
    logic [26+DUR_W:0] rom_b [4];

    always @(posedge clk) begin
        if (mem_a.mem_rd_en) mem_a.mem_data <= rom_a[mem_a.mem_addr];
        if (mem_b.mem_rd_en) mem_b.mem_data <= rom_b[mem_b.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_a[$];
    ev_t exp_b[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    function automatic string kname(input int k);
        case (k)
            0:       return "rd_addr";
            1:       return "notes";
            2:       return "song_done";
            default: return "playing";
        endcase
    endfunction

    task automatic observe(input int which, input int kind, input logic [31:0] value);
        ev_t e;
        bit  have;
        have = 1'b0;
        if (which == 0 && exp_a.size() > 0) begin
            e = exp_a.pop_front();
            have = 1'b1;
        end else if (which == 1 && exp_b.size() > 0) begin
            e = exp_b.pop_front();
            have = 1'b1;
        end
        n_checks++;
        if (!have) begin
            $display("FAIL unexpected_%s dut%0d: got value=%h at cycle %0d, required no event",
                     kname(kind), which, value, cyc);
        end else if (e.kind == kind && e.value == value && e.cyc == cyc) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d: got %s=%h at cycle %0d, required %s=%h at cycle %0d",
                     kname(e.kind), which, kname(kind), value, cyc, kname(e.kind), e.value, e.cyc);
        end
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual === required) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, actual, required);
    endtask

    task automatic ea(input int kind, input logic [31:0] value, input int c);
        exp_a.push_back('{kind, value, c});
    endtask

    task automatic eb(input int kind, input logic [31:0] value, input int c);
        exp_b.push_back('{kind, value, c});
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_a.size() + exp_b.size()) > 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    // Monitor for the 8-bit-address instance: reads, notes changes, done pulses, playing edges.
    initial begin
        logic [26:0] pn;
        logic        pp;
        pn = '0;
        pp = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pn = notes;
                pp = playing;
            end else begin
                if (mem_a.mem_rd_en) observe(0, 0, 32'(mem_a.mem_addr));
                if (notes !== pn) observe(0, 1, 32'(notes));
                pn = notes;
                if (song_done) observe(0, 2, 32'd1);
                if (playing !== pp) observe(0, 3, 32'(playing));
                pp = playing;
            end
        end
    end

    // Monitor for the 2-bit-address instance used for the wrap scenario.
    initial begin
        logic [26:0] pnb;
        pnb = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pnb = notes_b;
            end else begin
                if (mem_b.mem_rd_en) observe(1, 0, 32'(mem_b.mem_addr));
                if (notes_b !== pnb) observe(1, 1, 32'(notes_b));
                pnb = notes_b;
                if (song_done_b) observe(1, 2, 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        reset = 1'b1; play = 1'b0; stop = 1'b0; loop_en = 1'b0;
        play_b = 1'b0; stop_b = 1'b0; loop_en_b = 1'b0;
        for (int i = 0; i < 256; i++) rom_a[i] = '0;
        rom_a[0] = {8'd3, 27'h0000041};
        rom_a[1] = {8'd2, 27'h0208283};
        rom_a[2] = {8'd0, 27'h0000000};
        rom_b[0] = {8'd1, 27'h0000011};
        rom_b[1] = {8'd1, 27'h0000022};
        rom_b[2] = {8'd1, 27'h0000033};
        rom_b[3] = {8'd1, 27'h0000044};

        repeat (3) @(negedge clk);
        check("reset_notes", 32'(notes), 32'd0);
        check("reset_playing", 32'(playing), 32'd0);
        check("reset_rd_en", 32'(mem_a.mem_rd_en), 32'd0);
        check("reset_song_done", 32'(song_done), 32'd0);
        check("reset_addr", 32'(mem_a.mem_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic play with a redundant play pulse during the first HOLD.
        b = cyc;
        ea(0, 0, b+1);  ea(3, 1, b+1);  ea(1, 27'h0000041, b+3);
        ea(0, 1, b+15); ea(1, 27'h0208283, b+17);
        ea(0, 2, b+25); ea(1, 0, b+27); ea(2, 1, b+27); ea(3, 0, b+27);
        play = 1'b1; @(negedge clk); play = 1'b0;
        to_cycle(b+10);
        play = 1'b1; @(negedge clk); play = 1'b0;
        drain();

        // Loop from DONE, then stop during the second pass of event 1.
        loop_en = 1'b1;
        b = cyc;
        ea(0, 0, b+1);  ea(3, 1, b+1);  ea(1, 27'h0000041, b+3);
        ea(0, 1, b+15); ea(1, 27'h0208283, b+17);
        ea(0, 2, b+25); ea(0, 0, b+27); ea(1, 27'h0000041, b+29);
        ea(0, 1, b+41); ea(1, 27'h0208283, b+43);
        ea(1, 0, b+47); ea(3, 0, b+47);
        play = 1'b1; @(negedge clk); play = 1'b0;
        to_cycle(b+46);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        loop_en = 1'b0;
        drain();

        // Stop mid-HOLD, then stop and play together must stay idle.
        b = cyc;
        ea(0, 0, b+1); ea(3, 1, b+1); ea(1, 27'h0000041, b+3);
        ea(1, 0, b+9); ea(3, 0, b+9);
        play = 1'b1; @(negedge clk); play = 1'b0;
        to_cycle(b+8);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        drain();
        play = 1'b1; stop = 1'b1; @(negedge clk); play = 1'b0; stop = 1'b0;
        repeat (10) @(negedge clk);

        // Address wrap on the 4-entry song: 0,1,2,3,0 with no done pulse.
        b = cyc;
        eb(0, 0, b+1);  eb(1, 27'h11, b+3);
        eb(0, 1, b+4);  eb(1, 27'h22, b+6);
        eb(0, 2, b+7);  eb(1, 27'h33, b+9);
        eb(0, 3, b+10); eb(1, 27'h44, b+12);
        eb(0, 0, b+13); eb(1, 0, b+15);
        play_b = 1'b1; @(negedge clk); play_b = 1'b0;
        to_cycle(b+14);
        stop_b = 1'b1; @(negedge clk); stop_b = 1'b0;
        drain();

        while (exp_a.size() > 0) begin
            ev_t e;
            e = exp_a.pop_front();
            n_checks++;
            $display("FAIL missing_%s dut0: got no event, required value=%h at cycle %0d", kname(e.kind), e.value, e.cyc);
        end
        while (exp_b.size() > 0) begin
            ev_t e;
            e = exp_b.pop_front();
            n_checks++;
            $display("FAIL missing_%s dut1: got no event, required value=%h at cycle %0d", kname(e.kind), e.value, e.cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
